fp_rnd: RTL and testbench

FP_RND -- requirements
Module: fp_rnd

---
 rtl/fp_wire.sv | 79 +++++++
 rtl/fp_rnd.sv | 135 +++++++++++++
 tb/tb_fp_rnd.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/fp_wire.sv
// Shared types and constants for the floating-point rounding pipeline.
package fp_wire;

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4
    } rnd_mode_t;

    localparam logic [1:0]  FMT_SINGLE = 2'd0;
    localparam logic [1:0]  FMT_DOUBLE = 2'd1;
    localparam logic [63:0] NAN_DOUBLE = 64'h7FF8000000000000;
    localparam logic [63:0] NAN_SINGLE = 64'hFFFFFFFF7FC00000;
    localparam logic [31:0] NAN_BOX    = 32'hFFFFFFFF;

    typedef struct packed {
        logic               sig;
        logic signed [13:0] expo;
        logic [53:0]        mant;
        logic [1:0]         rema;
        logic [1:0]         fmt;
        logic [2:0]         rm;
        logic [2:0]         grs;
        logic               snan;
        logic               qnan;
        logic               dbz;
        logic               inf;
        logic               zero;
        logic               diff;
        logic               valid;
    } fp_rnd_in_type;

    typedef struct packed {
        logic [63:0] result;
        logic [4:0]  flags;
        logic        ready;
    } fp_rnd_out_type;

    // Mantissa is held post-normalisation without the hidden bit.
    typedef struct packed {
        logic               sig;
        logic signed [13:0] expo;
        logic [51:0]        mant;
        logic [1:0]         fmt;
        logic [2:0]         rm;
        logic               nx;
        logic               snan;
        logic               qnan;
        logic               dbz;
        logic               inf;
        logic               zero;
        logic               diff;
        logic               valid;
    } fp_rnd_reg_type_1;

    typedef struct packed {
        logic [63:0] result;
        logic [4:0]  flags;
        logic        ready;
    } fp_rnd_reg_type_2;

    localparam fp_rnd_reg_type_1 init_fp_rnd_reg_1 = '0;
    localparam fp_rnd_reg_type_2 init_fp_rnd_reg_2 = '0;

    function automatic logic [63:0] inf_val(input logic dbl, input logic sgn);
        return dbl ? {sgn, 11'h7FF, 52'h0} : {NAN_BOX, sgn, 8'hFF, 23'h0};
    endfunction

    function automatic logic [63:0] max_val(input logic dbl, input logic sgn);
        return dbl ? {sgn, 11'h7FE, {52{1'b1}}} : {NAN_BOX, sgn, 8'hFE, {23{1'b1}}};
    endfunction

    function automatic logic [63:0] zero_val(input logic dbl, input logic sgn);
        return dbl ? {sgn, 63'h0} : {NAN_BOX, sgn, 31'h0};
    endfunction

endpackage

// File: rtl/fp_rnd.sv
// Two-stage IEEE-754 rounding: stage 1 rounds and normalises, stage 2 packs
// the result, resolves overflow and special cases, and registers the output.
module fp_rnd
    import fp_wire::*;
(
    input  logic           clock,
    input  logic           reset,
    input  fp_rnd_in_type  fp_rnd_i,
    output fp_rnd_out_type fp_rnd_o
);

    fp_rnd_reg_type_1 r1, d1;
    fp_rnd_reg_type_2 r2, d2;

    logic               g, r, s, lsb, rup, dbl1;
    logic [54:0]        mant_r;
    logic signed [13:0] expo_n;

    always_comb begin
        d1     = init_fp_rnd_reg_1;
        g      = fp_rnd_i.grs[2];
        r      = fp_rnd_i.grs[1];
        s      = fp_rnd_i.grs[0];
        lsb    = fp_rnd_i.mant[0];
        dbl1   = (fp_rnd_i.fmt == FMT_DOUBLE);
        expo_n = fp_rnd_i.expo;

        case (fp_rnd_i.rm)
            RTZ:     rup = 1'b0;
            RDN:     rup = fp_rnd_i.sig & (fp_rnd_i.grs != 3'b000);
            RUP:     rup = ~fp_rnd_i.sig & (fp_rnd_i.grs != 3'b000);
            RMM:     rup = g;
            default: rup = g & (r | s | lsb);
        endcase

        mant_r = {1'b0, fp_rnd_i.mant} + {54'h0, rup};

        // A carry past the hidden bit renormalises; a subnormal that rounds
        // into the hidden bit becomes the smallest normal.
        if (dbl1) begin
            if (mant_r[53]) begin
                mant_r = mant_r >> 1;
                expo_n = fp_rnd_i.expo + 14'sd1;
            end else if (fp_rnd_i.expo == 14'sd0 && mant_r[52]) begin
                expo_n = 14'sd1;
            end
        end else begin
            if (mant_r[24]) begin
                mant_r = mant_r >> 1;
                expo_n = fp_rnd_i.expo + 14'sd1;
            end else if (fp_rnd_i.expo == 14'sd0 && mant_r[23]) begin
                expo_n = 14'sd1;
            end
        end

        d1.sig   = fp_rnd_i.sig;
        d1.expo  = expo_n;
        d1.mant  = mant_r[51:0];
        d1.fmt   = fp_rnd_i.fmt;
        d1.rm    = fp_rnd_i.rm;
        d1.nx    = (fp_rnd_i.grs != 3'b000);
        d1.snan  = fp_rnd_i.snan;
        d1.qnan  = fp_rnd_i.qnan;
        d1.dbz   = fp_rnd_i.dbz;
        d1.inf   = fp_rnd_i.inf;
        d1.zero  = fp_rnd_i.zero;
        d1.diff  = fp_rnd_i.diff;
        d1.valid = fp_rnd_i.valid;
    end

    logic               dbl2, of, nx, uf, to_max, zsgn;
    logic signed [13:0] e2;
    logic [63:0]        normal;

    always_comb begin
        d2   = init_fp_rnd_reg_2;
        e2   = r1.expo;
        dbl2 = (r1.fmt == FMT_DOUBLE);
        of   = dbl2 ? (e2 >= 14'sd2047) : (e2 >= 14'sd255);
        nx   = r1.nx | of;
        uf   = (e2 == 14'sd0) & nx;
        zsgn = r1.diff ? (r1.rm == RDN) : r1.sig;

        normal = dbl2 ? {r1.sig, e2[10:0], r1.mant[51:0]}
                      : {NAN_BOX, r1.sig, e2[7:0], r1.mant[22:0]};

        // Directed modes saturate to max finite when rounding away from the overflow side.
        case (r1.rm)
            RTZ:     to_max = 1'b1;
            RDN:     to_max = ~r1.sig;
            RUP:     to_max = r1.sig;
            default: to_max = 1'b0;
        endcase

        if (r1.snan) begin
            d2.result = dbl2 ? NAN_DOUBLE : NAN_SINGLE;
            d2.flags  = 5'b10000;
        end else if (r1.qnan) begin
            d2.result = dbl2 ? NAN_DOUBLE : NAN_SINGLE;
        end else if (r1.dbz) begin
            d2.result = inf_val(dbl2, r1.sig);
            d2.flags  = 5'b01000;
        end else if (r1.inf) begin
            d2.result = inf_val(dbl2, r1.sig);
        end else if (r1.zero) begin
            d2.result = zero_val(dbl2, zsgn);
        end else if (of) begin
            d2.result = to_max ? max_val(dbl2, r1.sig) : inf_val(dbl2, r1.sig);
            d2.flags  = {2'b00, 1'b1, 1'b0, 1'b1};
        end else begin
            d2.result = normal;
            d2.flags  = {3'b000, uf, nx};
        end
        d2.ready = 1'b1;

        if (!r1.valid) begin
            d2 = init_fp_rnd_reg_2;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r1 <= init_fp_rnd_reg_1;
            r2 <= init_fp_rnd_reg_2;
        end else begin
            r1 <= d1;
            r2 <= d2;
        end
    end

    assign fp_rnd_o.result = r2.result;
    assign fp_rnd_o.flags  = r2.flags;
    assign fp_rnd_o.ready  = r2.ready;

endmodule

// File: tb/tb_fp_rnd.sv
// Scoreboard bench for fp_rnd: directed vectors push expectations, a monitor
// pops and compares whenever ready is seen, including a 2-cycle latency check.
module tb_fp_rnd;
    import fp_wire::*;

    logic           clock = 1'b0;
    logic           reset;
    fp_rnd_in_type  in_v;
    fp_rnd_out_type out_v;

    fp_rnd dut (
        .clock   (clock),
        .reset   (reset),
        .fp_rnd_i(in_v),
        .fp_rnd_o(out_v)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  fl;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic fp_rnd_in_type mk(input logic [1:0] fmt, input logic [2:0] rm,
                                         input logic sig, input logic [13:0] expo,
                                         input logic [53:0] mant, input logic [2:0] grs);
        fp_rnd_in_type v;
        v       = '0;
        v.fmt   = fmt;
        v.rm    = rm;
        v.sig   = sig;
        v.expo  = expo;
        v.mant  = mant;
        v.grs   = grs;
        v.rema  = 2'b11;
        v.valid = 1'b1;
        return v;
    endfunction

    task automatic send(input fp_rnd_in_type v, input logic [63:0] res, input logic [4:0] fl);
        @(posedge clock);
        #1;
        in_v = v;
        q.push_back('{res, fl, cyc});
    endtask

    always @(negedge clock) begin
        if (out_v.ready) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ready actual=ready result=%h required=idle", out_v.result);
            end else begin
                mon_e = q.pop_front();
                chk("result", out_v.result, mon_e.res);
                chk("flags", {59'h0, out_v.flags}, {59'h0, mon_e.fl});
                chk("latency", 64'(cyc - mon_e.cyc), 64'd2);
            end
        end
    end

    fp_rnd_in_type v;

    initial begin
        reset = 1'b1;
        in_v  = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_result", out_v.result, 64'h0);
        chk("reset_flags", {59'h0, out_v.flags}, 64'h0);
        chk("reset_ready", {63'h0, out_v.ready}, 64'h0);
        @(posedge clock);
        #1 reset = 1'b0;

        send(mk(FMT_SINGLE, RNE, 0, 14'd127, 54'h800000, 3'b011), 64'hFFFFFFFF3F800000, 5'b00001);
        send(mk(FMT_DOUBLE, RUP, 0, 14'd1023, 54'h1FFFFFFFFFFFFF, 3'b001), 64'h4000000000000000, 5'b00001);
        send(mk(FMT_DOUBLE, RTZ, 0, 14'd2047, 54'h10000000000000, 3'b000), 64'h7FEFFFFFFFFFFFFF, 5'b00101);
        send(mk(FMT_DOUBLE, RNE, 0, 14'd2047, 54'h10000000000000, 3'b000), 64'h7FF0000000000000, 5'b00101);
        v = mk(FMT_DOUBLE, RNE, 0, 14'd0, 54'h0, 3'b000); v.snan = 1'b1;
        send(v, 64'h7FF8000000000000, 5'b10000);
        v = mk(FMT_DOUBLE, RNE, 1, 14'd0, 54'h0, 3'b000); v.dbz = 1'b1;
        send(v, 64'hFFF0000000000000, 5'b01000);
        v = mk(FMT_DOUBLE, RDN, 0, 14'd0, 54'h0, 3'b000); v.zero = 1'b1; v.diff = 1'b1;
        send(v, 64'h8000000000000000, 5'b00000);
        send(mk(FMT_DOUBLE, RNE, 0, 14'd0, 54'h0FFFFFFFFFFFFF, 3'b110), 64'h0010000000000000, 5'b00001);
        v = mk(FMT_SINGLE, RNE, 0, 14'd0, 54'h0, 3'b000); v.qnan = 1'b1;
        send(v, 64'hFFFFFFFF7FC00000, 5'b00000);
        v = mk(FMT_DOUBLE, RNE, 0, 14'd0, 54'h0, 3'b000); v.snan = 1'b1; v.qnan = 1'b1; v.inf = 1'b1;
        send(v, 64'h7FF8000000000000, 5'b10000);
        send(mk(FMT_SINGLE, RDN, 0, 14'd255, 54'h800000, 3'b000), 64'hFFFFFFFF7F7FFFFF, 5'b00101);
        send(mk(FMT_DOUBLE, RUP, 1, 14'd2047, 54'h10000000000000, 3'b000), 64'hFFEFFFFFFFFFFFFF, 5'b00101);
        send(mk(FMT_DOUBLE, RNE, 0, 14'd0, 54'h1, 3'b001), 64'h0000000000000001, 5'b00011);
        send(mk(FMT_DOUBLE, RNE, 0, 14'd1023, 54'h10000000000001, 3'b100), 64'h3FF0000000000002, 5'b00001);
        send(mk(FMT_DOUBLE, RNE, 0, 14'd1023, 54'h10000000000000, 3'b100), 64'h3FF0000000000000, 5'b00001);
        send(mk(FMT_SINGLE, RMM, 0, 14'd127, 54'h800000, 3'b100), 64'hFFFFFFFF3F800001, 5'b00001);
        send(mk(FMT_SINGLE, RDN, 1, 14'd127, 54'hFFFFFF, 3'b001), 64'hFFFFFFFFC0000000, 5'b00001);
        send(mk(FMT_DOUBLE, 3'd7, 0, 14'd1023, 54'h10000000000001, 3'b100), 64'h3FF0000000000002, 5'b00001);
        v = mk(FMT_SINGLE, RNE, 0, 14'd0, 54'h0, 3'b000); v.inf = 1'b1;
        send(v, 64'hFFFFFFFF7F800000, 5'b00000);
        v = mk(FMT_SINGLE, RDN, 1, 14'd0, 54'h0, 3'b000); v.zero = 1'b1;
        send(v, 64'hFFFFFFFF80000000, 5'b00000);
        send(mk(FMT_DOUBLE, RNE, 0, 14'd1023, 54'h10000000000000, 3'b000), 64'h3FF0000000000000, 5'b00000);

        @(posedge clock);
        #1 in_v = '0;
        repeat (4) @(posedge clock);

        // Four back-to-back inputs; reset on the second discards the first two.
        #1 in_v = mk(FMT_DOUBLE, RNE, 0, 14'd1023, 54'h10000000000000, 3'b000);
        @(posedge clock);
        #1;
        v = mk(FMT_DOUBLE, RNE, 0, 14'd0, 54'h0, 3'b000); v.snan = 1'b1;
        in_v  = v;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        in_v  = mk(FMT_SINGLE, RNE, 0, 14'd127, 54'h800000, 3'b011);
        q.push_back('{64'hFFFFFFFF3F800000, 5'b00001, cyc});
        @(negedge clock);
        chk("midreset_ready", {63'h0, out_v.ready}, 64'h0);
        @(posedge clock);
        #1;
        in_v = mk(FMT_DOUBLE, RUP, 0, 14'd1023, 54'h1FFFFFFFFFFFFF, 3'b001);
        q.push_back('{64'h4000000000000000, 5'b00001, cyc});
        @(posedge clock);
        #1 in_v = '0;

        repeat (6) @(posedge clock);
        @(negedge clock);
        chk("drained", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
